// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the result-RAM arbiter:
//   - wb_state_e : arbiter FSM states (IDLE, BURST, RD_WAIT)
//   - WB_BEATS   : beats per writeback burst
//   - RAM_AW/DW  : result SRAM address / data widths
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RD_WAIT = 2'd2
    } wb_state_e;

    localparam int WB_BEATS = 4;
    localparam int RAM_AW   = 8;
    localparam int RAM_DW   = 32;

endpackage

// File: rtl/wb_frame_cnt.sv
// -----------------------------------------------------------------------------
// wb_frame_cnt
// Counts completed writeback bursts and raises frame_ready once a full frame
// has been written. Flags an overrun when a write beat arrives while a frame
// is still waiting to be drained.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   burst_done    : one-cycle pulse on the 4th beat of a burst
//   wr_beat       : a writeback beat is going to the SRAM this cycle
//   frame_ack     : consumer has drained the frame
//   frame_ready   : level, full frame available
//   overrun_err   : sticky, write seen while frame_ready was high
// -----------------------------------------------------------------------------
module wb_frame_cnt
    import wb_pkg::*;
#(
    parameter int BURSTS_PER_FRAME = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic burst_done,
    input  logic wr_beat,
    input  logic frame_ack,
    output logic frame_ready,
    output logic overrun_err
);

    localparam int CW = $clog2(BURSTS_PER_FRAME) + 1;

    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          frame_ready_q, frame_ready_d;
    logic          overrun_q, overrun_d;
    logic          frame_done;

    always_comb begin
        burst_cnt_d   = burst_cnt_q;
        frame_ready_d = frame_ready_q;
        overrun_d     = overrun_q;
        frame_done    = 1'b0;

        if (burst_done) begin
            if (burst_cnt_q == CW'(BURSTS_PER_FRAME - 1)) begin
                frame_done  = 1'b1;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + CW'(1);
            end
        end

        // Completion has priority over a same-cycle acknowledge.
        if (frame_done) begin
            frame_ready_d = 1'b1;
        end else if (frame_ack) begin
            frame_ready_d = 1'b0;
        end

        if (wr_beat && frame_ready_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q   <= '0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            burst_cnt_q   <= burst_cnt_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign overrun_err = overrun_q;

endmodule

// File: rtl/wb_ram_arb.sv
// -----------------------------------------------------------------------------
// wb_ram_arb
// Single-port result-RAM arbiter. Writeback bursts always own the SRAM port;
// a readout requester is served in free cycles through a req/ack handshake.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   wb_we_n/wb_addr/wb_data   : writeback write port (strobe active-low)
//   rd_req/rd_addr/rd_ack     : readout request handshake
//   rd_valid/rd_data          : readout response
//   ram_we_n/ram_addr/ram_wdata/ram_rdata : SRAM port
//   frame_ready/frame_ack     : frame handshake
//   overrun_err/burst_err     : sticky protocol error flags
// -----------------------------------------------------------------------------
module wb_ram_arb
    import wb_pkg::*;
#(
    parameter int BURSTS_PER_FRAME = 16,
    parameter int RD_LAT           = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we_n,
    input  logic [RAM_AW-1:0] wb_addr,
    input  logic [RAM_DW-1:0] wb_data,
    input  logic              rd_req,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [RAM_DW-1:0] rd_data,
    output logic              ram_we_n,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_wdata,
    input  logic [RAM_DW-1:0] ram_rdata,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              overrun_err,
    output logic              burst_err
);

    wb_state_e         state_q, state_d;
    logic [1:0]        beat_q, beat_d;      // beats done in current burst; 0 = no burst
    logic [1:0]        lat_q, lat_d;        // cycles spent waiting for read data
    logic              rd_valid_q, rd_valid_d;
    logic [RAM_DW-1:0] rd_data_q, rd_data_d;
    logic              burst_err_q, burst_err_d;

    logic wr_beat;
    logic rd_issue;
    logic rd_done;
    logic burst_done;
    logic burst_abort;

    // Nothing reaches the SRAM while reset is held.
    assign wr_beat  = ~wb_we_n & ~rst;
    // IDLE implies no burst in progress, so this is the only free-port check.
    assign rd_issue = ~rst & wb_we_n & rd_req & (state_q == IDLE);
    assign rd_done  = (state_q == RD_WAIT) && (lat_q == 2'(RD_LAT));

    // Beat tracking runs independently of the read side so a burst can
    // start while a read is still waiting for its data.
    always_comb begin
        beat_d      = beat_q;
        burst_done  = 1'b0;
        burst_abort = 1'b0;
        if (wr_beat) begin
            if (beat_q == 2'(WB_BEATS - 1)) begin
                burst_done = 1'b1;
                beat_d     = 2'd0;
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end else if (beat_q != 2'd0) begin
            burst_abort = 1'b1;
            beat_d      = 2'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        burst_err_d = burst_err_q | burst_abort;

        unique case (state_q)
            IDLE: begin
                if (wr_beat) begin
                    state_d = BURST;
                end else if (rd_issue) begin
                    state_d = RD_WAIT;
                    lat_d   = 2'd1;
                end
            end
            BURST: begin
                if (beat_d == 2'd0) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = ram_rdata;
                    // Hand over to a burst that started during the wait.
                    state_d    = (beat_d != 2'd0) ? BURST : IDLE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            lat_q       <= 2'd0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            burst_err_q <= burst_err_d;
        end
    end

    // SRAM port mux: write beat, else read issue, else parked at zero.
    always_comb begin
        ram_we_n  = ~wr_beat;
        ram_wdata = wr_beat ? wb_data : '0;
        if (wr_beat) begin
            ram_addr = wb_addr;
        end else if (rd_issue) begin
            ram_addr = rd_addr;
        end else begin
            ram_addr = '0;
        end
    end

    assign rd_ack    = rd_issue;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign burst_err = burst_err_q;

    wb_frame_cnt #(
        .BURSTS_PER_FRAME(BURSTS_PER_FRAME)
    ) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .burst_done (burst_done),
        .wr_beat    (wr_beat),
        .frame_ack  (frame_ack),
        .frame_ready(frame_ready),
        .overrun_err(overrun_err)
    );

endmodule

// File: tb/tb_wb_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_ram_arb
// Drives directed and random writeback/readout traffic into wb_ram_arb and
// compares every cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_wb_ram_arb;

    localparam int BPF    = 16;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we_n;
    logic [7:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        ram_we_n;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        frame_ready;
    logic        frame_ack;
    logic        overrun_err;
    logic        burst_err;

    always #5 clk = ~clk;

    wb_ram_arb #(
        .BURSTS_PER_FRAME(BPF),
        .RD_LAT          (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we_n    (wb_we_n),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ram_we_n   (ram_we_n),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .frame_ready(frame_ready),
        .frame_ack  (frame_ack),
        .overrun_err(overrun_err),
        .burst_err  (burst_err)
    );

    // SRAM behavioural model with RD_LAT cycles of read latency.
    logic [31:0] sram    [256];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (!ram_we_n) sram[ram_addr] <= ram_wdata;
        rd_pipe[0] <= sram[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    // Reference model state
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          run   = 0;     // length of the current unbroken write run
    int          bursts = 0;
    int          frames = 0;
    int          rd_due = 0;
    bit          synced = 0;
    bit          m_valid, m_fr, m_ovr, m_berr, rd_out;
    logic [31:0] m_data, rd_exp;
    logic [7:0]  rd_iss_addr;
    logic [31:0] ref_mem [256];
    bit          host_req;
    logic [7:0]  host_addr;

    function automatic logic [31:0] pat(input int i);
        return 32'h5EED0000 ^ 32'(i * 32'h00010101);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational port, then advance the model across the clock edge.
    task automatic step(input bit r, input bit we_n, input logic [7:0] wa,
                        input logic [31:0] wd, input bit fa);
        bit         wr, issue, done_frame;
        logic [7:0] exp_addr;
        @(negedge clk);
        if (synced) begin
            chk("rd_valid",    32'(rd_valid),    32'(m_valid));
            chk("rd_data",     rd_data,          m_data);
            chk("frame_ready", 32'(frame_ready), 32'(m_fr));
            chk("overrun_err", 32'(overrun_err), 32'(m_ovr));
            chk("burst_err",   32'(burst_err),   32'(m_berr));
        end
        rst = r; wb_we_n = we_n; wb_addr = wa; wb_data = wd;
        rd_req = host_req; rd_addr = host_addr; frame_ack = fa;
        #1;
        wr    = !we_n && !r;
        // Port is free when no write this cycle and no burst left unfinished.
        issue = !r && host_req && !wr && (run % 4 == 0) && !rd_out;
        exp_addr = wr ? wa : (issue ? host_addr : 8'h00);
        chk("ram_we_n",  32'(ram_we_n), 32'(!wr));
        chk("ram_addr",  32'(ram_addr), 32'(exp_addr));
        chk("ram_wdata", ram_wdata,     wr ? wd : 32'h0);
        chk("rd_ack",    32'(rd_ack),   32'(issue));
        @(posedge clk);
        if (r) begin
            run = 0; bursts = 0; m_valid = 0; m_data = '0;
            m_fr = 0; m_ovr = 0; m_berr = 0; rd_out = 0; synced = 1;
        end else begin
            m_valid = rd_out && (cyc + 1 == rd_due);
            if (m_valid) begin
                m_data = rd_exp;
                rd_out = 0;
                $display("read  addr=%02h data=%08h cyc=%0d", rd_iss_addr, rd_exp, cyc + 1);
            end
            if (issue) begin
                rd_out      = 1;
                rd_due      = cyc + RD_LAT + 1;
                rd_exp      = ref_mem[host_addr];
                rd_iss_addr = host_addr;
            end
            done_frame = 0;
            if (wr) begin
                if (m_fr) m_ovr = 1;
                run++;
                if (run % 4 == 0) begin
                    bursts++;
                    if (bursts == BPF) begin
                        bursts = 0;
                        done_frame = 1;
                    end
                end
                ref_mem[wa] = wd;
            end else begin
                if (run % 4 != 0) m_berr = 1;
                run = 0;
            end
            if (done_frame) begin
                m_fr = 1;
                frames++;
                $display("frame %0d complete cyc=%0d", frames, cyc + 1);
            end else if (fa) begin
                m_fr = 0;
            end
        end
        if (issue) host_req = 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 8'h00, 32'h0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 8'h00, 32'h0, 0);
        $display("reset cyc=%0d", cyc);
    endtask

    task automatic burst(input logic [7:0] base, input int nbeats, input bit fa_last);
        for (int b = 0; b < nbeats; b++)
            step(0, 0, 8'(base + 8'(b)), $urandom, fa_last && (b == nbeats - 1));
    endtask

    initial begin
        logic [7:0] wa_ptr;
        int         wr_left;
        bit         fa;

        for (int i = 0; i < 256; i++) begin
            sram[i]    = pat(i);
            ref_mem[i] = pat(i);
        end
        host_req = 0; host_addr = 8'h00;
        rst = 1; wb_we_n = 1; wb_addr = 0; wb_data = 0;
        rd_req = 0; rd_addr = 0; frame_ack = 0;

        // Reset then quiet port
        do_reset(2);
        idle(10);

        // Single read on an idle port
        host_req = 1; host_addr = 8'h05;
        idle(4);

        // Read requested on the first beat of a burst
        host_req = 1; host_addr = 8'h21;
        burst(8'h00, 4, 0);
        idle(4);

        // Full frame, then a 17th burst before frame_ack
        do_reset(2);
        for (int k = 0; k < BPF; k++) begin
            burst(8'(k * 4), 4, 0);
            idle(1);
        end
        idle(2);
        burst(8'h00, 4, 0);
        idle(1);
        step(0, 1, 8'h00, 32'h0, 1);
        idle(3);

        // Aborted burst, then a full frame completing alongside frame_ack
        do_reset(2);
        burst(8'h10, 2, 0);
        idle(2);
        for (int k = 0; k < BPF; k++) burst(8'(k * 4), 4, k == BPF - 1);
        idle(3);

        // Reset while a read is waiting and a burst is in flight
        host_req = 1; host_addr = 8'h10;
        idle(1);
        step(1, 0, 8'h30, 32'hDEADBEEF, 0);
        idle(3);
        burst(8'h30, 2, 0);
        step(1, 0, 8'h32, 32'hCAFEF00D, 0);
        idle(2);
        host_req = 1; host_addr = 8'h11;
        idle(4);

        // Random traffic; even segments never abort bursts
        wa_ptr = 8'h00;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(2);
            wr_left = 0;
            for (int c = 0; c < 500; c++) begin
                if (!host_req && $urandom_range(0, 3) == 0) begin
                    host_req  = 1;
                    host_addr = 8'($urandom_range(0, 63));
                end
                if (wr_left == 0 && $urandom_range(0, 2) == 0) begin
                    if (seg % 2 == 1 && $urandom_range(0, 9) == 0)
                        wr_left = int'($urandom_range(1, 3));
                    else
                        wr_left = 4 * int'($urandom_range(1, 2));
                end
                fa = ($urandom_range(0, 39) == 0);
                if (wr_left > 0) begin
                    step(0, 0, wa_ptr, $urandom, fa);
                    wa_ptr = 8'((wa_ptr + 8'd1) & 8'h3F);
                    wr_left--;
                end else begin
                    step(0, 1, 8'h00, 32'h0, fa);
                end
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
